// File: rtl/mux_flop_checker.sv
// rtl/mux_flop_checker.sv - response checker for a 2:1 mux plus output flop
// Optional macro MUX_FLOP_CHECKER_STICKY_EN makes error_mux/error_flop sticky until reset.
module mux_flop_checker #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] dataIn0,
  input  logic [WIDTH-1:0] dataIn1,
  input  logic             selector,
  input  logic [WIDTH-1:0] outMux,
  input  logic [WIDTH-1:0] outFlop,
  output logic             error_mux,
  output logic             error_flop,
  output logic [CNT_W-1:0] check_count,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] CHECK = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [WIDTH-1:0] exp_mux;
  logic [WIDTH-1:0] exp_flop;
  logic             mux_mis;
  logic             flop_mis;

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = enable ? PRIME : IDLE;
      PRIME:   next_state = enable ? CHECK : IDLE;
      CHECK:   next_state = enable ? CHECK : IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign exp_mux = selector ? dataIn1 : dataIn0;

  // exp_flop only becomes meaningful after a PRIME edge, so the flop compare is CHECK-only
  assign mux_mis  = (state != IDLE) && (outMux != exp_mux);
  assign flop_mis = (state == CHECK) && (outFlop != exp_flop);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      exp_flop    <= '0;
      error_mux   <= 1'b0;
      error_flop  <= 1'b0;
      check_count <= '0;
      err_count   <= '0;
      busy        <= 1'b0;
    end else begin
      state <= next_state;
      busy  <= (next_state != IDLE);
      if (state != IDLE) begin
        exp_flop <= exp_mux;
      end
`ifdef MUX_FLOP_CHECKER_STICKY_EN
      error_mux  <= error_mux | mux_mis;
      error_flop <= error_flop | flop_mis;
`else
      // mismatch terms are zero in IDLE, which clears the per-cycle flags there
      error_mux  <= mux_mis;
      error_flop <= flop_mis;
`endif
      if ((state == CHECK) && (check_count != CNT_MAX)) begin
        check_count <= check_count + CNT_ONE;
      end
      if ((mux_mis || flop_mis) && (err_count != CNT_MAX)) begin
        err_count <= err_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_mux_flop_checker.sv
// tb/tb_mux_flop_checker.sv - scoreboard bench for mux_flop_checker (8-bit and 2-bit counter instances)
module tb_mux_flop_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [1:0] dataIn0;
  logic [1:0] dataIn1;
  logic       selector;
  logic [1:0] outMux;
  logic [1:0] outFlop;

  logic       error_mux, error_flop, busy;
  logic [7:0] check_count, err_count;
  logic       s_error_mux, s_error_flop, s_busy;
  logic [1:0] s_check_count, s_err_count;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic em;
    logic ef;
    logic bz;
    int   cc;
    int   ec;
  } exp_t;

  exp_t q[$];

  // reference model state
  int         m_state = 0;
  logic [1:0] m_exp_flop = 2'b00;
  logic       m_err_mux = 1'b0;
  logic       m_err_flop = 1'b0;
  int         m_cc = 0;
  int         m_ec = 0;
  logic [1:0] dut_flop = 2'b00;

  always #5 clk = ~clk;

  mux_flop_checker #(.WIDTH(2), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .dataIn0(dataIn0), .dataIn1(dataIn1), .selector(selector),
    .outMux(outMux), .outFlop(outFlop),
    .error_mux(error_mux), .error_flop(error_flop),
    .check_count(check_count), .err_count(err_count), .busy(busy)
  );

  mux_flop_checker #(.WIDTH(2), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable),
    .dataIn0(dataIn0), .dataIn1(dataIn1), .selector(selector),
    .outMux(outMux), .outFlop(outFlop),
    .error_mux(s_error_mux), .error_flop(s_error_flop),
    .check_count(s_check_count), .err_count(s_err_count), .busy(s_busy)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat3(input int v);
    return (v > 3) ? 3 : v;
  endfunction

  // drive one cycle, push the model's post-edge expectation, then pop and compare after the edge
  task automatic step(input logic rst, input logic en, input logic sel, input logic [1:0] d0,
                      input logic [1:0] d1, input logic bad_mux, input logic bad_flop);
    logic [1:0] em;
    logic       mm, fm;
    exp_t       e;
    em       = sel ? d1 : d0;
    reset    = rst;
    enable   = en;
    selector = sel;
    dataIn0  = d0;
    dataIn1  = d1;
    outMux   = bad_mux ? ~em : em;
    outFlop  = bad_flop ? ~dut_flop : dut_flop;
    if (rst) begin
      m_state = 0; m_exp_flop = 2'b00; m_err_mux = 1'b0; m_err_flop = 1'b0; m_cc = 0; m_ec = 0;
    end else begin
      mm = (m_state != 0) && (outMux != em);
      fm = (m_state == 2) && (outFlop != m_exp_flop);
`ifdef MUX_FLOP_CHECKER_STICKY_EN
      m_err_mux  = m_err_mux | mm;
      m_err_flop = m_err_flop | fm;
`else
      m_err_mux  = mm;
      m_err_flop = fm;
`endif
      if (m_state == 2) m_cc++;
      if (mm || fm) m_ec++;
      if (m_state != 0) m_exp_flop = em;
      m_state = !en ? 0 : (m_state == 0 ? 1 : 2);
    end
    e.em = m_err_mux; e.ef = m_err_flop; e.bz = (m_state != 0); e.cc = m_cc; e.ec = m_ec;
    q.push_back(e);
    @(posedge clk);
    dut_flop = em;
    #1;
    e = q.pop_front();
    check_val("error_mux", 32'(error_mux), 32'(e.em));
    check_val("error_flop", 32'(error_flop), 32'(e.ef));
    check_val("busy", 32'(busy), 32'(e.bz));
    check_val("check_count", 32'(check_count), e.cc);
    check_val("err_count", 32'(err_count), e.ec);
    check_val("sat_check_count", 32'(s_check_count), sat3(e.cc));
    check_val("sat_err_count", 32'(s_err_count), sat3(e.ec));
    check_val("sat_error_mux", 32'(s_error_mux), 32'(e.em));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; selector = 1'b0;
    dataIn0 = '0; dataIn1 = '0; outMux = '0; outFlop = '0;
    #1;
    step(1, 1, 0, 2'b00, 2'b00, 0, 0);
    step(1, 0, 0, 2'b00, 2'b00, 0, 0);
    // correct DUT: IDLE->PRIME edge then 7 edges from PRIME
    for (int i = 0; i < 8; i++) step(0, 1, 0, 2'b11, 2'b00, 0, 0);
    check_val("tp1_check_count", 32'(check_count), 32'd6);
    check_val("tp1_err_count", 32'(err_count), 32'd0);
    // single mux corruption in CHECK
    step(0, 1, 1, 2'b11, 2'b10, 1, 0);
    check_val("tp2_error_mux", 32'(error_mux), 32'd1);
    step(0, 1, 1, 2'b11, 2'b10, 0, 0);
    step(0, 1, 0, 2'b11, 2'b10, 0, 0);
    // stale flop, then flop and mux errors together
    step(0, 1, 0, 2'b11, 2'b10, 0, 1);
    check_val("tp3_error_flop", 32'(error_flop), 32'd1);
    step(0, 1, 0, 2'b11, 2'b10, 1, 1);
    step(0, 1, 1, 2'b11, 2'b01, 0, 0);
    // enable low mid-run, then re-prime
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b01, 2'b10, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b01, 2'b10, 0, 0);
    // consecutive mismatching CHECK edges saturate the 2-bit counters
    for (int i = 0; i < 5; i++) step(0, 1, 0, 2'b10, 2'b01, 1, 0);
    check_val("tp5_sat_err", 32'(s_err_count), 32'd3);
    check_val("tp5_sat_chk", 32'(s_check_count), 32'd3);
    // random traffic with occasional enable drops
    for (int i = 0; i < 40; i++)
      step(0, ($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
    // reset during CHECK with err_count nonzero, enable still high
    step(0, 1, 0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 2'b00, 0, 0);
    step(0, 1, 0, 2'b00, 2'b00, 1, 0);
    step(0, 1, 0, 2'b00, 2'b00, 1, 0);
    step(1, 1, 0, 2'b00, 2'b00, 1, 1);
    check_val("rst_err_count", 32'(err_count), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_error_mux", 32'(error_mux), 32'd0);
    for (int i = 0; i < 4; i++) step(0, 1, 1, 2'b01, 2'b11, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_flop_checker.md
# mux_flop_checker

Synthesizable response checker for the 2:1 mux + output flop pair. It sits on the opposite side of the stimulus generator: it samples the same `dataIn0`, `dataIn1` and `selector` the generator drives, along with the DUT's `outMux`/`outFlop`. It computes the expected combinational and registered results itself, compares them cycle by cycle, and reports per-cycle mismatches plus saturating pass/error counters.

## Interface
- `WIDTH`, 2, data width of `dataIn0`, `dataIn1`, `outMux`, `outFlop`
- `CNT_W`, 8, width of `check_count` and `err_count`

- `clk`  input  1  single clock; all sampling on rising edge
- `reset`  input  1  synchronous, active-high reset
- `enable`  input  1  checking active while high
- `dataIn0`  input  WIDTH  mux input 0 as driven to DUT
- `dataIn1`  input  WIDTH  mux input 1 as driven to DUT
- `selector`  input  1  mux select as driven to DUT (1 selects `dataIn1`)
- `outMux`  input  WIDTH  DUT combinational mux output
- `outFlop`  input  WIDTH  DUT registered mux output
- `error_mux`  output  1  mux mismatch flag
- `error_flop`  output  1  flop mismatch flag
- `check_count`  output  CNT_W  number of cycles in which the flop comparison was performed
- `err_count`  output  CNT_W  number of cycles with any mismatch
- `busy`  output  1  high in PRIME or CHECK

## Operation
- FSM states: IDLE, PRIME, CHECK.
  - IDLE: `enable`=1 → PRIME; otherwise stay.
  - PRIME: `enable`=1 → CHECK; `enable`=0 → IDLE.
  - CHECK: `enable`=1 → stay; `enable`=0 → IDLE.
- Expected mux value `exp_mux` = `selector` ? `dataIn1` : `dataIn0`. It is combinational from the current inputs.
- `exp_flop` register loads `exp_mux` on every edge where the state is PRIME or CHECK. It holds in IDLE.
- Mux compare (`outMux` != `exp_mux`) is performed in PRIME and CHECK.
- Flop compare (`outFlop` != `exp_flop`) is performed only in CHECK, because `exp_flop` is not valid until one PRIME edge has passed.
- `check_count` increments once per CHECK edge.
- `err_count` increments by exactly 1 per edge with any mismatch, even when both the mux and the flop mismatch.
- Both counters saturate at 2^CNT_W−1 and never wrap.
- Leaving CHECK (to IDLE) holds both counters. Re-entering always passes through PRIME again.
- Compares use bitwise `!=`. X/Z detection is out of scope for this block.

## Timing
- Reset values: state=IDLE, `exp_flop`=0, `error_mux`=0, `error_flop`=0, `check_count`=0, `err_count`=0, `busy`=0.
- Reset asserted mid-CHECK returns every output to its reset value on the next edge; reset has priority over `enable`.
- Latency: a mismatch sampled at edge N is visible on `error_mux`/`error_flop` after edge N. `err_count` reflects it after the same edge. Registered outputs, one cycle of latency.
- A flop mismatch at edge N means the `outFlop` sampled at N ≠ the `exp_mux` sampled at edge N−1.
- `busy` is registered from the next state and is high the cycle after the IDLE→PRIME edge.
- Counter at max plus a new event: the counter stays at max, while the error flags still follow the compare.

## Configuration
- `MUX_FLOP_CHECKER_STICKY_EN`
  - Defined: `error_mux`/`error_flop` are sticky. Once set they stay 1 until `reset`; IDLE does not clear them.
  - Undefined: the flags are per-cycle. Each equals the compare result of the latest PRIME/CHECK edge, and they are forced to 0 on any edge taken in IDLE.

## Test plan
- Reset, then `enable`=1 with `selector`=0, `dataIn0`=2'b11, a correct DUT for 7 edges → `error_*`=0, `err_count`=0, `check_count`=6 (first edge is PRIME).
- `selector`=1, `dataIn1`=2'b10, `outMux` forced to 2'b01 for one edge in CHECK → `error_mux`=1 the next cycle, `err_count`=1. Without sticky, `error_mux` returns to 0 the cycle after; with sticky, it stays 1.
- Flop held at stale value: `outFlop`=2'b00 when the prior-cycle `exp_mux`=2'b11 → `error_flop`=1, `err_count`+1. A simultaneous `outMux` error in that same cycle still adds only 1.
- `enable` low for 3 cycles mid-run, then high → counters hold, one PRIME edge occurs with no flop compare, and `check_count` resumes from the held value.
- `CNT_W`=2, 5 consecutive mismatching CHECK edges → `err_count`=3 and `check_count`=3 (both saturated, no wrap).
- Assert `reset` during CHECK with `err_count`=2 → after the edge, state=IDLE, all counters=0 and `busy`=0, including in the sticky build.
